// File: rtl/reg_bank_writer_pkg.sv
// Shared types and constants for the register-bank write side.
package reg_bank_writer_pkg;

  localparam int REG_W  = 16;
  localparam int NREGS  = 16;
  localparam int ADDR_W = 4;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  data;
  } wr_req_t;

  function automatic logic [NREGS-1:0] onehot16(input logic [ADDR_W-1:0] addr, input logic en);
    if (en) begin
      onehot16 = 16'h0001 << addr;
    end else begin
      onehot16 = 16'h0000;
    end
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// 4-to-16 one-hot decoder with enable; zero bits set when disabled.
module reg_onehot_dec
  import reg_bank_writer_pkg::*;
(
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_en,
  output logic [NREGS-1:0]  o_sel
);

  assign o_sel = onehot16(i_addr, i_en);

endmodule

// File: rtl/reg_bank_writer.sv
// Write side of the 16x16 register bank: one-cycle write stage, commit, flat view, read selects.
// Optional macro WR_FWD_EN overlays the staged write onto regs_flat.
module reg_bank_writer #(
  parameter int WIDTH   = 16,
  parameter int NREGS   = 16,
  parameter int ZERO_R0 = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [3:0]             wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [3:0]             rd_addr_a,
  input  logic [3:0]             rd_addr_b,
  input  logic                   rd_en_a,
  input  logic                   rd_en_b,
  output logic [NREGS*WIDTH-1:0] regs_flat,
  output logic [NREGS-1:0]       sel_a,
  output logic [NREGS-1:0]       sel_b,
  output logic                   wr_pending,
  output logic [15:0]            wr_count
);
  import reg_bank_writer_pkg::*;

  wr_req_t          r_stage;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [15:0]      r_count;
  logic             w_commit_en;
  logic [NREGS-1:0] w_wr_vec;

  // Writes to register 0 are dropped entirely when it is hard-wired to zero.
  assign w_commit_en = r_stage.en && !((ZERO_R0 != 0) && (r_stage.addr == 4'd0));

  reg_onehot_dec u_dec_a  (.i_addr(rd_addr_a),    .i_en(rd_en_a),     .o_sel(sel_a));
  reg_onehot_dec u_dec_b  (.i_addr(rd_addr_b),    .i_en(rd_en_b),     .o_sel(sel_b));
  reg_onehot_dec u_dec_wr (.i_addr(r_stage.addr), .i_en(w_commit_en), .o_sel(w_wr_vec));

  // Stage incoming request, commit the previous one, count commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stage <= '0;
      r_count <= 16'd0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_stage.en <= wr_en;
      if (wr_en) begin
        r_stage.addr <= wr_addr;
        r_stage.data <= wr_data;
      end
      if (w_commit_en) begin
        r_count <= r_count + 16'd1;
      end
      for (int i = 0; i < NREGS; i++) begin
        if (w_wr_vec[i]) begin
          r_regs[i] <= r_stage.data;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NREGS; gi++) begin : g_slot
    logic w_fwd;
`ifdef WR_FWD_EN
    assign w_fwd = r_stage.en && (r_stage.addr == ADDR_W'(gi));
`else
    assign w_fwd = 1'b0;
`endif
    assign regs_flat[gi*WIDTH +: WIDTH] = ((ZERO_R0 != 0) && (gi == 0)) ? '0 :
                                          (w_fwd ? r_stage.data : r_regs[gi]);
  end

  assign wr_pending = r_stage.en;
  assign wr_count   = r_count;

endmodule

// File: tb/tb_reg_bank_writer.sv
// Directed, scoreboard-checked bench for reg_bank_writer (works with or without WR_FWD_EN).
module tb_reg_bank_writer;

  logic         clk = 1'b0;
  logic         reset, wr_en, rd_en_a, rd_en_b;
  logic [3:0]   wr_addr, rd_addr_a, rd_addr_b;
  logic [15:0]  wr_data;
  logic [255:0] regs_flat;
  logic [15:0]  sel_a, sel_b, wr_count;
  logic         wr_pending;

  reg_bank_writer #(.WIDTH(16), .NREGS(16), .ZERO_R0(1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_en_a(rd_en_a), .rd_en_b(rd_en_b),
    .regs_flat(regs_flat), .sel_a(sel_a), .sel_b(sel_b),
    .wr_pending(wr_pending), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [255:0] flat;
    logic         pend;
    logic [15:0]  cnt;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  logic [15:0] m_regs [16];
  logic        m_en;
  logic [3:0]  m_addr;
  logic [15:0] m_data;
  logic [15:0] m_count;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    logic [15:0]  v;
    f = '0;
    for (int i = 0; i < 16; i++) begin
      v = m_regs[i];
`ifdef WR_FWD_EN
      if (m_en && (m_addr == 4'(i))) v = m_data;
`endif
      if (i == 0) v = 16'h0000;
      f[i*16 +: 16] = v;
    end
    return f;
  endfunction

  function automatic logic [15:0] slot(input int i);
    return regs_flat[i*16 +: 16];
  endfunction

  // One clock: drive inputs, advance the model, push expectation, then pop and compare.
  task automatic step(input logic rst, input logic en, input logic [3:0] addr, input logic [15:0] data);
    exp_t e;
    exp_t g;
    reset = rst; wr_en = en; wr_addr = addr; wr_data = data;
    if (rst) begin
      for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
      m_en = 1'b0; m_addr = 4'd0; m_data = 16'h0000; m_count = 16'd0;
    end else begin
      if (m_en && (m_addr != 4'd0)) begin
        m_regs[m_addr] = m_data;
        m_count = m_count + 16'd1;
      end
      m_en = en;
      if (en) begin
        m_addr = addr;
        m_data = data;
      end
    end
    e.flat = model_flat(); e.pend = m_en; e.cnt = m_count;
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    check("flat",    regs_flat,           g.flat);
    check("pending", {255'd0, wr_pending}, {255'd0, g.pend});
    check("count",   {240'd0, wr_count},   {240'd0, g.cnt});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0000;
    rd_addr_a = 4'd0; rd_addr_b = 4'd0; rd_en_a = 1'b0; rd_en_b = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_en = 1'b0; m_addr = 4'd0; m_data = 16'h0000; m_count = 16'd0;

    // Reset then idle
    step(1'b1, 1'b0, 4'd0, 16'h0000);
    step(1'b0, 1'b0, 4'd0, 16'h0000);
    check("rst_flat", regs_flat, 256'd0);
    check("rst_sel_a", {240'd0, sel_a}, 256'd0);
    check("rst_sel_b", {240'd0, sel_b}, 256'd0);
    check("rst_cnt", {240'd0, wr_count}, 256'd0);

    // Single write, addr 5
    step(1'b0, 1'b1, 4'd5, 16'hBEEF);
    check("w5_pend", {255'd0, wr_pending}, {255'd0, 1'b1});
`ifdef WR_FWD_EN
    check("w5_fwd", {240'd0, slot(5)}, {240'd0, 16'hBEEF});
`else
    check("w5_early", {240'd0, slot(5)}, 256'd0);
`endif
    step(1'b0, 1'b0, 4'd0, 16'h0000);
    check("w5_slot", {240'd0, slot(5)}, {240'd0, 16'hBEEF});
    check("w5_cnt", {240'd0, wr_count}, {240'd0, 16'd1});

    // Back-to-back writes to addr 3 from a clean reset
    step(1'b1, 1'b0, 4'd0, 16'h0000);
    step(1'b0, 1'b1, 4'd3, 16'h1111);
    step(1'b0, 1'b1, 4'd3, 16'h2222);
    step(1'b0, 1'b1, 4'd3, 16'h3333);
    step(1'b0, 1'b0, 4'd0, 16'h0000);
    check("b2b_slot3", {240'd0, slot(3)}, {240'd0, 16'h3333});
    check("b2b_cnt", {240'd0, wr_count}, {240'd0, 16'd3});
    check("b2b_others", regs_flat & ~(256'hFFFF << 48), 256'd0);

    // Register 0 is hard-wired; addr 15 still writes
    step(1'b0, 1'b1, 4'd0, 16'hFFFF);
    check("r0_pend", {255'd0, wr_pending}, {255'd0, 1'b1});
    step(1'b0, 1'b1, 4'd15, 16'h0001);
    check("r0_slot", {240'd0, slot(0)}, 256'd0);
    check("r0_cnt", {240'd0, wr_count}, {240'd0, 16'd3});
    step(1'b0, 1'b0, 4'd0, 16'h0000);
    check("r15_slot", {240'd0, slot(15)}, {240'd0, 16'h0001});
    check("r15_cnt", {240'd0, wr_count}, {240'd0, 16'd4});

    // Read selects
    rd_addr_a = 4'd9; rd_en_a = 1'b1; #1;
    check("sel_a_9", {240'd0, sel_a}, {240'd0, 16'h0200});
    rd_en_a = 1'b0; #1;
    check("sel_a_off", {240'd0, sel_a}, 256'd0);
    rd_addr_b = 4'd0; rd_en_b = 1'b1; #1;
    check("sel_b_0", {240'd0, sel_b}, {240'd0, 16'h0001});
    rd_addr_b = 4'd15; #1;
    check("sel_b_15", {240'd0, sel_b}, {240'd0, 16'h8000});
    rd_en_b = 1'b0;

    // Staged write lost when reset hits its commit edge
    step(1'b1, 1'b0, 4'd0, 16'h0000);
    step(1'b0, 1'b1, 4'd7, 16'hA5A5);
    step(1'b1, 1'b0, 4'd0, 16'h0000);
    check("rstw_slot7", {240'd0, slot(7)}, 256'd0);
    check("rstw_pend", {255'd0, wr_pending}, 256'd0);
    check("rstw_cnt", {240'd0, wr_count}, 256'd0);
    step(1'b0, 1'b0, 4'd0, 16'h0000);
    check("rstw_slot7_late", {240'd0, slot(7)}, 256'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_writer.md
Name: reg_bank_writer

Overview:
- Write side of the 16x16 register bank whose outputs feed the shared 16-bit tri-state read bus.
- Accepts an encoded write request from the datapath and stages it for one cycle. Commits it into one of 16 registers, then presents all 16 register values flat to the read-bus buffer.
- Decodes two 4-bit read addresses into the one-hot 16-bit read-select vectors the read-bus buffer expects.
- Owns register state, write sequencing, and read-select generation.

Parameters:
- WIDTH, 16, data width of each register and of wr_data.
- NREGS, 16, register count. Fixed at 16 so the one-hot selects are 16 bits wide. Any other value is unsupported.
- ZERO_R0, 1, when 1: register 0 reads 0 and writes to address 0 are dropped (not counted).

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- wr_en  input  1  write request this cycle
- wr_addr  input  4  encoded destination register
- wr_data  input  WIDTH  write data
- rd_addr_a  input  4  encoded read address, port A
- rd_addr_b  input  4  encoded read address, port B
- rd_en_a  input  1  enable for port A read select
- rd_en_b  input  1  enable for port B read select
- regs_flat  output  NREGS*WIDTH  register i on bits [i*WIDTH +: WIDTH]
- sel_a  output  NREGS  one-hot read select for bus A (drives the buffer read vector)
- sel_b  output  NREGS  one-hot read select for bus B
- wr_pending  output  1  a staged write awaits commit
- wr_count  output  16  number of committed writes, wraps

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset (clk edge with reset=1):
  - all registers clear to 0;
  - the staged write is discarded (wr_pending=0);
  - wr_count clears to 0.
  - An in-flight staged write at reset is lost, never committed.
- Stage (edge N): if wr_en=1, capture wr_addr/wr_data into the stage and set wr_pending=1. Otherwise set wr_pending=0.
- Commit (edge N+1):
  - if wr_pending=1, write the staged data into the register at the staged address and increment wr_count by 1 (wraps 0xFFFF->0);
  - a new request can be staged on the same edge, so one write per cycle is sustained.
- Latency:
  - write visible on regs_flat after edge N+1;
  - 2 cycles from wr_en to visibility, unless WR_FWD_EN is defined.
- Back-to-back writes to the same address commit in order; the last one wins.
- ZERO_R0=1:
  - a staged write to address 0 still sets wr_pending;
  - its commit has no effect and does not increment wr_count;
  - regs_flat[WIDTH-1:0] is always 0.
- Read selects are combinational:
  - sel_a = rd_en_a ? (1 << rd_addr_a) : 0; sel_b likewise.
  - Exactly one bit or zero bits are set, which guarantees a single bus driver.
- Read selects do not depend on write state; the read-bus consumer sees the current regs_flat view.
- Bus-fight prevention is the caller's duty: sel_a and sel_b drive separate buses.

Optional Feature:
- Macro WR_FWD_EN.
- Defined:
  - regs_flat overlays the staged write, so while wr_pending=1 the slot at the staged address shows the staged data;
  - the write becomes visible 1 cycle after wr_en;
  - the ZERO_R0 rule still holds on slot 0.
- Undefined: regs_flat shows committed registers only.
- Architectural state and wr_count are identical either way.

Decomposition:
- Shared package holds:
  - REG_W=16, NREGS=16, ADDR_W=4;
  - a write-request struct {en, addr, data};
  - a function onehot16(addr, en).
- One sub-module, reg_onehot_dec (4-to-16 decoder with enable), instantiated three times: sel_a, sel_b, and the commit write-enable vector.

Test Plan:
- Reset then idle: all regs_flat=0, sel_a=sel_b=0, wr_pending=0, wr_count=0.
- wr_en=1, addr=5, data=0xBEEF for one cycle:
  - wr_pending=1 next cycle;
  - slot 5 reads 0xBEEF after the following edge (one edge earlier with WR_FWD_EN);
  - wr_count=1.
- Writes to addr 3 on consecutive cycles with data 0x1111, 0x2222, 0x3333:
  - slot 3 ends at 0x3333;
  - wr_count=3;
  - no other slot changes.
- ZERO_R0=1, write addr 0 data 0xFFFF: slot 0 stays 0 and wr_count unchanged. Then write addr 15 data 0x0001: slot 15=0x0001.
- rd_addr_a=9 with rd_en_a=1 -> sel_a=0x0200; rd_en_a=0 -> sel_a=0x0000; rd_addr_b=0 with rd_en_b=1 -> sel_b=0x0001.
- Stage a write to addr 7, assert reset on the commit edge: slot 7 stays 0, wr_pending=0, wr_count=0.
